// File: rtl/miriscv_lsu.sv
// Load/store unit: issues one data-memory access per core request over a req/rvalid
// handshake, shapes byte enables and store lanes, extends load data, flags errors.
module miriscv_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic        r_req, w_req_next;
  logic        r_we, w_we_next;
  logic [3:0]  r_be, w_be_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic [2:0]  r_size, w_size_next;
  logic [1:0]  r_off, w_off_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic [31:0] r_data, w_data_next;
  logic        r_err, w_err_next;

  logic        w_legal;
  logic        w_misaligned;
  logic [3:0]  w_be_new;
  logic [31:0] w_wdata_new;
  logic [31:0] w_lane;
  logic [31:0] w_load_ext;

  // Request decode: size legality, alignment, lane enables and replicated store data.
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    w_be_new     = 4'b1111;
    w_wdata_new  = lsu_data_i;
    case (lsu_size_i)
      3'd0, 3'd4: w_legal = 1'b1;
      3'd1, 3'd5: begin
        w_legal      = 1'b1;
        w_misaligned = lsu_addr_i[0];
      end
      3'd2: begin
        w_legal      = 1'b1;
        w_misaligned = (lsu_addr_i[1:0] != 2'b00);
      end
      default: w_legal = 1'b0;
    endcase
    case (lsu_size_i[1:0])
      2'd0: begin
        w_be_new    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata_new = {4{lsu_data_i[7:0]}};
      end
      2'd1: begin
        w_be_new    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        w_wdata_new = {2{lsu_data_i[15:0]}};
      end
      default: begin
        w_be_new    = 4'b1111;
        w_wdata_new = lsu_data_i;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by the latched size.
  always_comb begin
    w_lane = data_rdata_i >> {r_off, 3'b000};
    case (r_size)
      3'd0:    w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'd4:    w_load_ext = {24'd0, w_lane[7:0]};
      3'd1:    w_load_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'd5:    w_load_ext = {16'd0, w_lane[15:0]};
      default: w_load_ext = data_rdata_i;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_we_next    = r_we;
    w_be_next    = r_be;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_size_next  = r_size;
    w_off_next   = r_off;
    w_cnt_next   = r_cnt;
    w_data_next  = r_data;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsu_req_i) begin
          if (!w_legal || w_misaligned) begin
            w_state_next = S_DONE;
            w_err_next   = 1'b1;
          end else begin
            w_state_next = S_BUSY;
            w_req_next   = 1'b1;
            w_we_next    = lsu_we_i;
            w_be_next    = w_be_new;
            w_addr_next  = {lsu_addr_i[31:2], 2'b00};
            w_wdata_next = w_wdata_new;
            w_size_next  = lsu_size_i;
            w_off_next   = lsu_addr_i[1:0];
            w_cnt_next   = 8'd0;
          end
        end
      end
      S_BUSY: begin
        // rvalid takes priority over the timeout check in the same cycle.
        if (data_rvalid_i) begin
          w_state_next = S_DONE;
          w_req_next   = 1'b0;
          if (!r_we) begin
            w_data_next = w_load_ext;
          end
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_next = S_DONE;
          w_req_next   = 1'b0;
          w_data_next  = 32'd0;
          w_err_next   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 3'd0;
      r_off   <= 2'd0;
      r_cnt   <= 8'd0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
      r_we    <= w_we_next;
      r_be    <= w_be_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_size  <= w_size_next;
      r_off   <= w_off_next;
      r_cnt   <= w_cnt_next;
      r_data  <= w_data_next;
      r_err   <= w_err_next;
    end
  end

  // Reset gates the stall so the core is released while reset is held.
  assign lsu_stall_req_o = lsu_req_i & (r_state != S_DONE) & ~rst_i;
  assign lsu_err_o       = r_err;
  assign lsu_data_o      = r_data;
  assign data_req_o      = r_req;
  assign data_we_o       = r_we;
  assign data_be_o       = r_be;
  assign data_addr_o     = r_addr;
  assign data_wdata_o    = r_wdata;

endmodule
